panda_risc_v_ibus_ctrler: RTL and testbench

- Instruction bus control unit: the responder side of the IFU's IMEM access request/response interface.
- Accepts IMEM access requests and checks PC alignment. Forwards aligned requests onto a simple in-order command/response instruction bus (ICB-style).
- Returns exactly one registered response per accepted request, in request order, with an error code (normal, misaligned, bus error, timeout).
- Sits between the IMEM access controller and the instruction memory/interconnect.

---
 rtl/panda_risc_v_ibus_pkg.sv | 15 +
 rtl/panda_risc_v_ibus_order_fifo.sv | 54 +++++
 rtl/panda_risc_v_ibus_ctrler.sv | 141 ++++++++++++++
 tb/tb_panda_risc_v_ibus_ctrler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_ibus_pkg.sv
// Shared constants for the instruction bus controller: response error codes,
// the default timeout threshold and the order-FIFO count width.
package panda_risc_v_ibus_pkg;

    localparam logic [1:0] IMEM_ACCESS_NORMAL = 2'b00;
    localparam logic [1:0] PC_UNALIGNED       = 2'b01;
    localparam logic [1:0] BUS_ERR            = 2'b10;
    localparam logic [1:0] TIMEOUT            = 2'b11;

    localparam int DEFAULT_IBUS_TIMEOUT_TH = 16;

    // Wide enough for the largest legal depth (4) plus the zero state.
    localparam int ORDER_CNT_W = 3;

endpackage

// File: rtl/panda_risc_v_ibus_order_fifo.sv
// Register FIFO, 1 bit wide, recording whether each outstanding request was
// misaligned so responses can be returned in request order.
module panda_risc_v_ibus_order_fifo
    import panda_risc_v_ibus_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]       mem;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [ORDER_CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == ORDER_CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/panda_risc_v_ibus_ctrler.sv
// IMEM access responder: checks PC alignment, forwards aligned requests to the
// in-order instruction bus and returns one registered response per request.
// Optional bus timeout enabled by defining PANDA_IBUS_TIMEOUT_EN.
module panda_risc_v_ibus_ctrler
    import panda_risc_v_ibus_pkg::*;
#(
    parameter int simulation_delay   = 1,
    parameter int IBUS_OUTSTANDING_N = 4,
    parameter int IBUS_TIMEOUT_TH    = DEFAULT_IBUS_TIMEOUT_TH
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] imem_access_req_addr,
    input  logic        imem_access_req_read,
    input  logic [31:0] imem_access_req_wdata,
    input  logic [3:0]  imem_access_req_wmask,
    input  logic        imem_access_req_valid,
    output logic        imem_access_req_ready,
    output logic [31:0] imem_access_resp_rdata,
    output logic [1:0]  imem_access_resp_err,
    output logic        imem_access_resp_valid,
    output logic [31:0] ibus_cmd_addr,
    output logic        ibus_cmd_read,
    output logic [31:0] ibus_cmd_wdata,
    output logic [3:0]  ibus_cmd_wmask,
    output logic        ibus_cmd_valid,
    input  logic        ibus_cmd_ready,
    input  logic [31:0] ibus_rsp_rdata,
    input  logic        ibus_rsp_err,
    input  logic        ibus_rsp_valid,
    output logic        ibus_rsp_ready
);

    if (IBUS_OUTSTANDING_N < 1 || IBUS_OUTSTANDING_N > 4) begin : g_bad_outstanding
        $error("IBUS_OUTSTANDING_N must be in 1..4");
    end
    if (IBUS_TIMEOUT_TH < 2 || IBUS_TIMEOUT_TH > 255) begin : g_bad_timeout
        $error("IBUS_TIMEOUT_TH must be in 2..255");
    end
    if (simulation_delay < 0) begin : g_bad_delay
        $error("simulation_delay must not be negative");
    end

    logic       misalign;
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_mis;
    logic       head_bus;
    logic       drop_mode;
    logic       rsp_take;
    logic       pop_mis;
    logic       pop_bus;
    logic       pop_to;
    logic       fifo_pop;
    logic [2:0] drop_cnt;

    assign misalign = (imem_access_req_addr[1:0] != 2'b00);

    assign ibus_cmd_addr  = imem_access_req_addr;
    assign ibus_cmd_read  = imem_access_req_read;
    assign ibus_cmd_wdata = imem_access_req_wdata;
    assign ibus_cmd_wmask = imem_access_req_wmask;
    assign ibus_cmd_valid = imem_access_req_valid & ~misalign & ~fifo_full;

    assign imem_access_req_ready = ~fifo_full & (misalign | ibus_cmd_ready);
    assign accept                = imem_access_req_valid & imem_access_req_ready;

    // Dropped responses belong to timed-out commands and outrank the head.
    assign head_bus       = ~fifo_empty & ~head_mis;
    assign drop_mode      = (drop_cnt != 3'd0);
    assign ibus_rsp_ready = drop_mode | head_bus;
    assign rsp_take       = ibus_rsp_valid & ibus_rsp_ready;

    assign pop_mis  = ~fifo_empty & head_mis;
    assign pop_bus  = rsp_take & ~drop_mode & head_bus;
    assign fifo_pop = pop_mis | pop_bus | pop_to;

    panda_risc_v_ibus_order_fifo #(
        .DEPTH(IBUS_OUTSTANDING_N)
    ) u_order_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .push_data(misalign),
        .pop      (fifo_pop),
        .head_data(head_mis),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef PANDA_IBUS_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_run;

    // A response in the threshold cycle clears to_run, so it wins over the timeout.
    assign to_run = head_bus & ~drop_mode & ~ibus_rsp_valid;
    assign pop_to = to_run & (to_cnt == 8'(IBUS_TIMEOUT_TH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt   <= 8'd0;
            drop_cnt <= 3'd0;
        end else begin
            if (fifo_pop)
                to_cnt <= 8'd0;
            else if (to_run)
                to_cnt <= to_cnt + 8'd1;

            if (pop_to)
                drop_cnt <= drop_cnt + 3'd1;
            else if (rsp_take & drop_mode)
                drop_cnt <= drop_cnt - 3'd1;
        end
    end
`else
    assign pop_to   = 1'b0;
    assign drop_cnt = 3'd0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            imem_access_resp_valid <= 1'b0;
            imem_access_resp_err   <= IMEM_ACCESS_NORMAL;
            imem_access_resp_rdata <= 32'd0;
        end else begin
            imem_access_resp_valid <= fifo_pop;
            if (pop_mis) begin
                imem_access_resp_err   <= PC_UNALIGNED;
                imem_access_resp_rdata <= 32'd0;
            end else if (pop_bus) begin
                imem_access_resp_err   <= ibus_rsp_err ? BUS_ERR : IMEM_ACCESS_NORMAL;
                imem_access_resp_rdata <= ibus_rsp_rdata;
            end else if (pop_to) begin
                imem_access_resp_err   <= TIMEOUT;
                imem_access_resp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_panda_risc_v_ibus_ctrler.sv
// Directed self-checking bench for panda_risc_v_ibus_ctrler: a combinational
// vector table followed by hand-written multi-cycle sequences.
module tb_panda_risc_v_ibus_ctrler;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] req_addr;
    logic        req_read;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        resp_valid;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_valid;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    panda_risc_v_ibus_ctrler dut (
        .clk                   (clk),
        .resetn                (resetn),
        .imem_access_req_addr  (req_addr),
        .imem_access_req_read  (req_read),
        .imem_access_req_wdata (req_wdata),
        .imem_access_req_wmask (req_wmask),
        .imem_access_req_valid (req_valid),
        .imem_access_req_ready (req_ready),
        .imem_access_resp_rdata(resp_rdata),
        .imem_access_resp_err  (resp_err),
        .imem_access_resp_valid(resp_valid),
        .ibus_cmd_addr         (cmd_addr),
        .ibus_cmd_read         (cmd_read),
        .ibus_cmd_wdata        (cmd_wdata),
        .ibus_cmd_wmask        (cmd_wmask),
        .ibus_cmd_valid        (cmd_valid),
        .ibus_cmd_ready        (cmd_ready),
        .ibus_rsp_rdata        (rsp_rdata),
        .ibus_rsp_err          (rsp_err),
        .ibus_rsp_valid        (rsp_valid),
        .ibus_rsp_ready        (rsp_ready)
    );

    always @(negedge clk)
        if (resetn && resp_valid) pulses++;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic        cmd_ready;
        logic        exp_req_ready;
        logic        exp_cmd_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string name, input logic [1:0] err, input logic [31:0] rdata);
        chk({name, ".valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, ".err"}, {30'd0, resp_err}, {30'd0, err});
        chk({name, ".rdata"}, resp_rdata, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_pulses;

        vecs[0] = '{32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0102, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0101, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0103, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_010C, 1'b1, 1'b1, 1'b1, 1'b1};

        resetn    = 1'b0;
        req_addr  = 32'd0;
        req_read  = 1'b1;
        req_wdata = 32'd0;
        req_wmask = 4'd0;
        req_valid = 1'b0;
        cmd_ready = 1'b1;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        rsp_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst.rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // Combinational handshake table, applied without letting any request be clocked in.
        for (int i = 0; i < 7; i++) begin
            req_addr  = vecs[i].addr;
            req_valid = vecs[i].valid;
            cmd_ready = vecs[i].cmd_ready;
            #1;
            chk($sformatf("vec%0d.req_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].exp_req_ready});
            chk($sformatf("vec%0d.cmd_valid", i), {31'd0, cmd_valid}, {31'd0, vecs[i].exp_cmd_valid});
            chk($sformatf("vec%0d.cmd_addr", i), cmd_addr, vecs[i].addr);
            chk($sformatf("vec%0d.rsp_ready", i), {31'd0, rsp_ready}, 32'd0);
            req_valid = 1'b0;
            tick();
        end
        cmd_ready = 1'b1;

        // T1: aligned read, bus answers two cycles after the command.
        req_addr = 32'h0000_0100; req_valid = 1'b1; #1;
        chk("t1.cmd_valid", {31'd0, cmd_valid}, 32'd1);
        chk("t1.req_ready", {31'd0, req_ready}, 32'd1);
        tick(); req_valid = 1'b0;
        chk("t1.rsp_ready", {31'd0, rsp_ready}, 32'd1);
        chk("t1.no_early_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0013;
        tick(); rsp_valid = 1'b0;
        chk_resp("t1", 2'b00, 32'h0000_0013);
        tick();
        chk("t1.pulse_end", {31'd0, resp_valid}, 32'd0);

        // T2: misaligned PC never reaches the bus.
        req_addr = 32'h0000_0102; req_valid = 1'b1; cmd_ready = 1'b0; #1;
        chk("t2.cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("t2.req_ready", {31'd0, req_ready}, 32'd1);
        tick(); req_valid = 1'b0; cmd_ready = 1'b1; #1;
        chk("t2.rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk("t2.no_early_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        chk_resp("t2", 2'b01, 32'd0);
        tick();

        // T3: fill all four slots, fifth request stalls until one answer returns.
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h0000_0200 + 32'(4 * i); req_valid = 1'b1;
            tick();
        end
        req_addr = 32'h0000_0210; #1;
        chk("t3.full_req_ready", {31'd0, req_ready}, 32'd0);
        chk("t3.full_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_00A0;
        tick(); rsp_valid = 1'b0; #1;
        chk_resp("t3.r0", 2'b00, 32'h0000_00A0);
        chk("t3.req_ready_back", {31'd0, req_ready}, 32'd1);
        tick(); req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rsp_valid = 1'b1; rsp_rdata = 32'h0000_00A0 + 32'(k);
            tick();
            chk_resp($sformatf("t3.r%0d", k), 2'b00, 32'h0000_00A0 + 32'(k));
        end
        rsp_valid = 1'b0;
        tick();
        chk("t3.drained_rsp_ready", {31'd0, rsp_ready}, 32'd0);

        // T4: aligned / misaligned / aligned, bus holds a response ready throughout.
        req_valid = 1'b1;
        req_addr = 32'h0000_0300; tick();
        req_addr = 32'h0000_0301; tick();
        req_addr = 32'h0000_0304; tick();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_1111;
        tick(); rsp_rdata = 32'h0000_2222; #1;
        chk("t4.mis_head_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk_resp("t4.a", 2'b00, 32'h0000_1111);
        tick();
        chk("t4.bus_head_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        chk_resp("t4.b", 2'b01, 32'd0);
        tick(); rsp_valid = 1'b0;
        chk_resp("t4.c", 2'b00, 32'h0000_2222);
        tick();

        // T5: write forwarded with its fields, bus replies with an error.
        req_addr = 32'h0000_0400; req_read = 1'b0; req_wdata = 32'hCAFE_F00D;
        req_wmask = 4'b0101; req_valid = 1'b1; #1;
        chk("t5.cmd_read", {31'd0, cmd_read}, 32'd0);
        chk("t5.cmd_wdata", cmd_wdata, 32'hCAFE_F00D);
        chk("t5.cmd_wmask", {28'd0, cmd_wmask}, 32'h5);
        chk("t5.cmd_addr", cmd_addr, 32'h0000_0400);
        tick(); req_valid = 1'b0; req_read = 1'b1;
        rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h0000_DEAD;
        tick(); rsp_valid = 1'b0; rsp_err = 1'b0;
        chk_resp("t5", 2'b10, 32'h0000_DEAD);
        tick();
        exp_pulses = 11;

`ifdef PANDA_IBUS_TIMEOUT_EN
        // T6: silent bus times out, the late response is dropped.
        req_addr = 32'h0000_0500; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t6.latency", 32'(n), 32'd16);
        chk_resp("t6.timeout", 2'b11, 32'd0);
        chk("t6.drop_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0BAD;
        tick(); rsp_valid = 1'b0; #1;
        chk("t6.dropped_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("t6.idle_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        req_addr = 32'h0000_0504; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_600D;
        tick(); rsp_valid = 1'b0;
        chk_resp("t6.next", 2'b00, 32'h0000_600D);
        tick();
        exp_pulses = 13;
`else
        n = 0;
`endif

        tick();
        chk("total_pulses", 32'(pulses), 32'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
